// File: rtl/cricket_pkg.sv
// cricket_pkg: event codes, sequencer states and result encodings for the scoreboard
package cricket_pkg;
    localparam logic [2:0] EV_DOT   = 3'd0;
    localparam logic [2:0] EV_ONE   = 3'd1;
    localparam logic [2:0] EV_TWO   = 3'd2;
    localparam logic [2:0] EV_THREE = 3'd3;
    localparam logic [2:0] EV_FOUR  = 3'd4;
    localparam logic [2:0] EV_WIDE  = 3'd5;
    localparam logic [2:0] EV_SIX   = 3'd6;
    localparam logic [2:0] EV_WKT   = 3'd7;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PLAY   = 3'd1,
        ISSUE  = 3'd2,
        SETTLE = 3'd3,
        CHECK  = 3'd4,
        BREAK  = 3'd5,
        DONE   = 3'd6
    } state_t;

    localparam logic [1:0] RES_NONE = 2'd0;
    localparam logic [1:0] RES_T1   = 2'd1;
    localparam logic [1:0] RES_T2   = 2'd2;
    localparam logic [1:0] RES_TIE  = 2'd3;

    localparam int BALLS_PER_OVER = 6;
endpackage

// File: rtl/crease_tracker.sv
// crease_tracker: batter ids at each end, with run swaps, wicket replacement and over-end swap
module crease_tracker
    import cricket_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       init,
    input  logic       ev,
    input  logic [2:0] code,
    input  logic       ovr,
    input  logic [3:0] wickets,
    output logic [3:0] striker,
    output logic [3:0] non_striker
);
    logic       run_swap;
    logic [3:0] s_ev, n_ev;

    assign run_swap = code == EV_ONE || code == EV_THREE;

    // wickets is the pre-ball count, so the next unused id is wickets + 2
    always_comb begin
        s_ev = run_swap ? non_striker : striker;
        n_ev = run_swap ? striker : non_striker;
        if (code == EV_WKT) s_ev = wickets + 4'd2;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            striker     <= 4'd0;
            non_striker <= 4'd1;
        end else if (init) begin
            striker     <= 4'd0;
            non_striker <= 4'd1;
        end else if (ev) begin
            striker     <= ovr ? n_ev : s_ev;
            non_striker <= ovr ? s_ev : n_ev;
        end
    end
endmodule

// File: rtl/innings_ctrl.sv
// innings_ctrl: match sequencer forwarding scorer events to the datapath and applying match rules
module innings_ctrl
    import cricket_pkg::*;
#(
    parameter int MAX_OVERS = 5,
    parameter int MAX_WKTS  = 10,
    parameter int SCORE_W   = 7
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               ev_valid,
    input  logic [2:0]         ev_code,
    output logic               ev_ready,
    input  logic [SCORE_W-1:0] ds_score,
    output logic               ds_valid,
    output logic [2:0]         ds_code,
    output logic               ds_clear,
    output logic               innings,
    output logic [2:0]         overs,
    output logic [2:0]         balls,
    output logic [3:0]         wickets,
    output logic [3:0]         striker,
    output logic [3:0]         non_striker,
    output logic [SCORE_W:0]   target,
    output logic               over_end,
    output logic [2:0]         phase,
    output logic [1:0]         result
);
    localparam int TW = SCORE_W + 1;

    state_t        state, state_nxt;
    logic [2:0]    code_q;
    logic          accept, legal, wkt, ovr, init, end_inn;
    logic [TW-1:0] sc;

    assign sc       = {1'b0, ds_score};
    assign accept   = ev_ready & ev_valid;
    assign legal    = ev_code != EV_WIDE;
    assign wkt      = ev_code == EV_WKT;
    assign ovr      = legal && balls == 3'(BALLS_PER_OVER - 1);
    assign end_inn  = wickets == 4'(MAX_WKTS) || overs == 3'(MAX_OVERS) || (innings && sc >= target);
    assign ds_valid = state == ISSUE;
    assign ds_code  = code_q;
    assign ds_clear = init;
    assign phase    = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ev_ready  = 1'b0;
        init      = 1'b0;
        case (state)
            IDLE, BREAK: if (start) begin
                init      = 1'b1;
                state_nxt = PLAY;
            end
            PLAY: begin
                ev_ready = 1'b1;
                if (ev_valid) state_nxt = ISSUE;
            end
            ISSUE:   state_nxt = SETTLE;
            SETTLE:  state_nxt = CHECK;
            CHECK:   state_nxt = !end_inn ? PLAY : innings ? DONE : BREAK;
            default: state_nxt = state;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            code_q   <= 3'd0;
            innings  <= 1'b0;
            overs    <= 3'd0;
            balls    <= 3'd0;
            wickets  <= 4'd0;
            target   <= '0;
            result   <= RES_NONE;
            over_end <= 1'b0;
        end else begin
            over_end <= accept & ovr;
            if (accept) begin
                code_q  <= ev_code;
                balls   <= ovr ? 3'd0 : balls + {2'b0, legal};
                overs   <= overs + {2'b0, ovr};
                wickets <= wickets + {3'b0, wkt};
            end
            if (init) begin
                overs   <= 3'd0;
                balls   <= 3'd0;
                wickets <= 4'd0;
                innings <= state == BREAK;
            end
            // score settled by now, so the end-of-innings decision uses the final total
            if (state == CHECK && end_inn) begin
                if (!innings) target <= sc + TW'(1);
                else          result <= sc >= target ? RES_T2 : sc == target - TW'(1) ? RES_TIE : RES_T1;
            end
        end
    end

    crease_tracker u_crease (
        .clk        (clk),
        .reset      (reset),
        .init       (init),
        .ev         (accept),
        .code       (ev_code),
        .ovr        (ovr),
        .wickets    (wickets),
        .striker    (striker),
        .non_striker(non_striker)
    );
endmodule

// File: tb/tb_innings_ctrl.sv
// tb_innings_ctrl: directed and random matches checked every cycle against a match-level model
module tb_innings_ctrl;
    localparam int MO = 2;
    localparam int MW = 3;
    localparam int SW = 7;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          ev_valid = 1'b0;
    logic [2:0]    ev_code = 3'd0;
    logic          ev_ready, ds_valid, ds_clear, innings, over_end;
    logic [2:0]    ds_code, overs, balls, phase;
    logic [3:0]    wickets, striker, non_striker;
    logic [SW:0]   target;
    logic [1:0]    result;
    logic [SW-1:0] score;

    int checks = 0;
    int errors = 0;

    int m_ph, m_inn, m_legal, m_wk, m_s, m_n, m_tgt, m_res, m_code, m_oe;

    innings_ctrl #(.MAX_OVERS(MO), .MAX_WKTS(MW), .SCORE_W(SW)) dut (
        .clk(clk), .reset(reset), .start(start), .ev_valid(ev_valid), .ev_code(ev_code),
        .ev_ready(ev_ready), .ds_score(score), .ds_valid(ds_valid), .ds_code(ds_code),
        .ds_clear(ds_clear), .innings(innings), .overs(overs), .balls(balls), .wickets(wickets),
        .striker(striker), .non_striker(non_striker), .target(target), .over_end(over_end),
        .phase(phase), .result(result)
    );

    always #5 clk = ~clk;

    function automatic int runs(input logic [2:0] c);
        return c == 3'd5 ? 1 : c == 3'd7 ? 0 : int'(c);
    endfunction

    // stand-in score datapath: runs land one cycle after the command
    always_ff @(posedge clk or posedge reset) begin
        if (reset)         score <= '0;
        else if (ds_clear) score <= '0;
        else if (ds_valid) score <= score + SW'(runs(ds_code));
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // match-level model: total legal balls, batter ids per end, phase timeline
    initial begin
        int t;
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                m_ph = 0; m_inn = 0; m_legal = 0; m_wk = 0; m_s = 0; m_n = 1;
                m_tgt = 0; m_res = 0; m_code = 0; m_oe = 0;
            end else begin
                m_oe = 0;
                if ((m_ph == 0 || m_ph == 5) && start) begin
                    m_inn = (m_ph == 5) ? 1 : 0;
                    m_legal = 0; m_wk = 0; m_s = 0; m_n = 1; m_ph = 1;
                end else if (m_ph == 1 && ev_valid) begin
                    m_code = int'(ev_code);
                    if (m_code == 1 || m_code == 3) begin t = m_s; m_s = m_n; m_n = t; end
                    if (m_code == 7) begin m_wk++; m_s = m_wk + 1; end
                    if (m_code != 5) begin
                        m_legal++;
                        if (m_legal % 6 == 0) begin m_oe = 1; t = m_s; m_s = m_n; m_n = t; end
                    end
                    m_ph = 2;
                end else if (m_ph == 2 || m_ph == 3) begin
                    m_ph++;
                end else if (m_ph == 4) begin
                    if (m_wk == MW || m_legal / 6 == MO || (m_inn == 1 && int'(score) >= m_tgt)) begin
                        if (m_inn == 0) begin
                            m_tgt = int'(score) + 1;
                            m_ph = 5;
                        end else begin
                            m_res = int'(score) >= m_tgt ? 2 : int'(score) == m_tgt - 1 ? 3 : 1;
                            m_ph = 6;
                        end
                    end else m_ph = 1;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            #2;
            chk("ev_ready", int'(ev_ready), int'(m_ph == 1));
            chk("ds_valid", int'(ds_valid), int'(m_ph == 2));
            if (m_ph == 2) chk("ds_code", int'(ds_code), m_code);
            chk("ds_clear", int'(ds_clear), int'((m_ph == 0 || m_ph == 5) && start));
            chk("innings", int'(innings), m_inn);
            chk("overs", int'(overs), m_legal / 6);
            chk("balls", int'(balls), m_legal % 6);
            chk("wickets", int'(wickets), m_wk);
            chk("striker", int'(striker), m_s);
            chk("non_striker", int'(non_striker), m_n);
            chk("target", int'(target), m_tgt);
            chk("over_end", int'(over_end), m_oe);
            chk("phase", int'(phase), m_ph);
            chk("result", int'(result), m_res);
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; start = 1'b0; ev_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send(input logic [2:0] c);
        int n = 0;
        @(negedge clk);
        ev_valid = 1'b1;
        ev_code  = c;
        #1;
        while (!ev_ready && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!ev_ready) chk("send_timeout", 0, 1);
        @(negedge clk);
        ev_valid = 1'b0;
        ev_code  = 3'($urandom_range(0, 7));
    endtask

    task automatic wait_ph(input int p);
        int n = 0;
        while (int'(phase) != p && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("wait_phase", int'(phase), p);
    endtask

    initial begin
        logic [2:0] six[6];
        six = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1};
        @(negedge clk);
        #2;
        chk("rst_phase", int'(phase), 0);
        chk("rst_non_striker", int'(non_striker), 1);
        chk("rst_striker", int'(striker), 0);
        chk("rst_target", int'(target), 0);
        @(negedge clk);
        reset = 1'b0;

        do_start();
        send(3'd1);
        #2;
        chk("t1_valid", int'(ds_valid), 1);
        chk("t1_code", int'(ds_code), 1);
        chk("t1_striker", int'(striker), 1);
        chk("t1_non", int'(non_striker), 0);
        chk("t1_balls", int'(balls), 1);
        for (int k = 0; k < 4; k++) begin
            chk("t1_ready_gap", int'(ev_ready), int'(k == 3));
            @(negedge clk);
            #2;
        end

        do_reset();
        do_start();
        foreach (six[i]) send(six[i]);
        #2;
        chk("t2_over_end", int'(over_end), 1);
        chk("t2_overs", int'(overs), 1);
        chk("t2_balls", int'(balls), 0);
        chk("t2_striker", int'(striker), 0);
        for (int k = 0; k < 2; k++) begin
            send(3'd5);
            #2;
            chk("t3_code", int'(ds_code), 5);
            chk("t3_balls", int'(balls), 0);
            chk("t3_striker", int'(striker), 0);
        end
        for (int k = 0; k < 3; k++) begin
            send(3'd7);
            #2;
            chk("t4_wickets", int'(wickets), k + 1);
            chk("t4_striker", int'(striker), k + 2);
        end
        wait_ph(5);
        #2;
        chk("t4_target", int'(target), 4);

        do_start();
        #2;
        chk("t5_innings", int'(innings), 1);
        chk("t5_wickets", int'(wickets), 0);
        send(3'd4);
        wait_ph(6);
        #2;
        chk("t5_win", int'(result), 2);
        ev_valid = 1'b1;
        repeat (3) @(negedge clk);
        ev_valid = 1'b0;
        chk("t5_hold", int'(phase), 6);

        do_reset();
        do_start();
        foreach (six[i]) if (i < 4) send(i == 0 ? 3'd4 : 3'd7);
        wait_ph(5);
        #2;
        chk("tie_target", int'(target), 5);
        do_start();
        foreach (six[i]) if (i < 4) send(i == 0 ? 3'd4 : 3'd7);
        wait_ph(6);
        #2;
        chk("tie_result", int'(result), 3);

        for (int m = 0; m < 6; m++) begin
            int g = 0;
            do_reset();
            while (int'(phase) != 6 && g < 1000) begin
                g++;
                if (phase == 3'd0 || phase == 3'd5) begin
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                    do_start();
                end else if (phase == 3'd1) begin
                    if ($urandom_range(0, 2) == 0) @(negedge clk);
                    send(3'($urandom_range(0, 7)));
                end else @(negedge clk);
            end
            chk("rand_done", int'(phase), 6);
        end

        do_reset();
        do_start();
        send(3'd2);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("t6_phase", int'(phase), 0);
        chk("t6_valid", int'(ds_valid), 0);
        chk("t6_code", int'(ds_code), 0);
        chk("t6_balls", int'(balls), 0);
        chk("t6_non", int'(non_striker), 1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #2;
            chk("t6_no_valid", int'(ds_valid), 0);
        end
        reset = 1'b0;
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/innings_ctrl.md
Name: innings_ctrl

Overview:
Match sequencer for the cricket scoreboard. It accepts scorer delivery events over a valid/ready handshake and forwards each one to the score-keeping datapath as a one-cycle command. It also owns the match rules: legal-ball and over counting, wickets, striker rotation, innings changeover with target capture, and the final result. It sits between the debounced scorer inputs and the score datapath, and reads the datapath's running score back.

Parameters:
MAX_OVERS, 5, overs per innings (1..7)
MAX_WKTS, 10, wickets that end an innings (1..10)
SCORE_W, 7, width of the datapath score

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
start  in  1  pulse; starts innings 0 from IDLE, innings 1 from BREAK
ev_valid  in  1  delivery event valid
ev_code  in  3  0-4 runs, 5 wide, 6 six, 7 wicket
ev_ready  out  1  event accepted when ev_valid & ev_ready
ds_score  in  SCORE_W  running score from the datapath
ds_valid  out  1  one-cycle command strobe to the datapath
ds_code  out  3  registered copy of the accepted ev_code
ds_clear  out  1  one-cycle datapath clear
innings  out  1  0 = first innings, 1 = second innings
overs  out  3  completed overs in this innings
balls  out  3  legal balls in the current over (0..5)
wickets  out  4  wickets in this innings
striker  out  4  batter id on strike
non_striker  out  4  batter id at the other end
target  out  SCORE_W+1  first-innings score + 1; 0 until captured
over_end  out  1  one-cycle pulse when an over completes
phase  out  3  state encoding
result  out  2  0 none, 1 team 1 wins, 2 team 2 wins, 3 tie

Behaviour:
- Reset (asynchronous) values: every output 0 except non_striker = 1; phase = IDLE. Reset mid-innings abandons the match with no datapath command issued.
- States and encodings: IDLE=0, PLAY=1, ISSUE=2, SETTLE=3, CHECK=4, BREAK=5, DONE=6.
- IDLE, start: pulse ds_clear, go to PLAY.
- ev_ready = 1 only in PLAY. Events offered in any other state are held off, not dropped.
- Accept in PLAY: latch ev_code and go to ISSUE.
- ISSUE: ds_valid = 1 and ds_code = latched code for exactly one cycle. The team scores ISSUE as the cycle where 'A gets it' (the command reaches the datapath); this is the only cycle ds_valid is high.
- SETTLE: wait one cycle for ds_score to update.
- CHECK: evaluate the end conditions below, then go to PLAY, BREAK or DONE.
- Throughput: one event every 4 cycles; ev_ready is next high 4 cycles after an accept.
- Rule update happens on the accept edge (PLAY to ISSUE):
  - Codes 0-4 and 6 are legal balls: balls += 1.
  - Codes 1 and 3 swap striker and non_striker.
  - Code 5 (wide): no ball counted, no swap.
  - Code 7 (wicket): legal ball; wickets += 1; striker = wickets_new + 1, which is the next unused batter id.
- Over completion: when balls would reach 6, set balls = 0, overs += 1, pulse over_end in ISSUE, then swap ends.
  - The over-end swap applies after any event swap or wicket replacement.
  - A wicket on the 6th ball therefore leaves the new batter at the non-striker end.
- End of innings, checked in CHECK: wickets == MAX_WKTS, or overs == MAX_OVERS, or (innings == 1 and ds_score >= target).
- End of innings 0:
  - target = ds_score + 1 (zero-extended), go to BREAK.
  - In BREAK, start pulses ds_clear; overs, balls and wickets reset to 0; striker = 0, non_striker = 1; innings = 1; go to PLAY.
- End of innings 1: go to DONE with result set as follows.
  - ds_score >= target gives 2.
  - ds_score == target - 1 gives 3.
  - Otherwise 1.
  - DONE holds every output until reset.
- start is ignored outside IDLE and BREAK.
- Counters never wrap, because the end checks stop play first (MAX_OVERS <= 7, MAX_WKTS <= 10).

Decomposition:
- Package cricket_pkg holds:
  - event code constants: EV_DOT..EV_FOUR, EV_WIDE=5, EV_SIX=6, EV_WKT=7;
  - the state enum;
  - result constants RES_NONE, RES_T1, RES_T2, RES_TIE;
  - BALLS_PER_OVER = 6.
- One natural sub-module: crease_tracker. It holds striker, non_striker, and the swap and new-batter logic, driven by the event strobe, code, over-complete flag and wicket count.

Test Plan:
1. Set MAX_OVERS=2, MAX_WKTS=3. Send reset, start, then code 1 -> ds_clear pulses once; ds_valid for one cycle with ds_code=1; striker=1, non_striker=0; balls=1; ev_ready low for 3 cycles.
2. Send six legal codes 0,0,0,0,0,1 from a fresh innings -> over_end pulses once; overs=1, balls=0; the code-1 swap followed by the over-end swap leaves striker=0.
3. Send codes 5,5 -> ds_valid twice with code 5; balls unchanged; no swap.
4. Datapath tracks the score. Send three code-7 events -> wickets=3, striker ids 2 then 3 then 4; CHECK goes to BREAK; target = ds_score + 1.
5. In BREAK, start; innings 1; drive ds_score = target -> DONE, result=2. Repeat with the innings ending at target-1 -> result=3.
6. Assert reset in SETTLE mid-innings -> every output returns to its reset value immediately; phase=0; no further ds_valid.
